// File: rtl/fc_mac_controller.sv
// fc_mac_controller
// Sequences one fully-connected layer pass: sweeps fc_rows weight addresses,
// multiplies each accepted activation by parallel_fc_PE weight lanes, and
// accumulates one signed sum per lane. The finished vector is offered on a
// valid/ready output and stays visible on out_data until the next start.
module fc_mac_controller #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 9,
    parameter int parallel_fc_PE = 100,
    parameter int fc_rows        = 32,
    parameter int ACC_WIDTH      = 2*DATA_WIDTH+ADDR_WIDTH
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                in_valid,
    input  logic [DATA_WIDTH-1:0]               in_data,
    output logic                                in_ready,
    output logic [ADDR_WIDTH-1:0]               address_fc,
    output logic                                read_en_MM_fc,
    output logic                                enable_MM_out_fc,
    input  logic [DATA_WIDTH*parallel_fc_PE-1:0] dataMainMemo_fc,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [ACC_WIDTH*parallel_fc_PE-1:0] out_data,
    output logic                                busy,
    output logic                                done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int PROD_WIDTH = 2*DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(fc_rows - 1);

    state_t                        state;
    state_t                        state_next;
    logic [ADDR_WIDTH-1:0]         row_cnt;
    logic                          handshake;
    logic                          clear_acc;
    logic signed [PROD_WIDTH-1:0]  prod [parallel_fc_PE];
    logic signed [ACC_WIDTH-1:0]   acc  [parallel_fc_PE];

    // An activation is consumed only while the sweep is running.
    assign handshake  = in_valid & in_ready;

    // The weight row index is exposed only during RUN; it reads 0 otherwise.
    assign address_fc = (state == RUN) ? row_cnt : '0;

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-state control outputs.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next       = state;
        in_ready         = 1'b0;
        read_en_MM_fc    = 1'b0;
        enable_MM_out_fc = 1'b0;
        out_valid        = 1'b0;
        busy             = 1'b0;
        clear_acc        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    clear_acc  = 1'b1;
                end
            end
            RUN: begin
                in_ready         = 1'b1;
                read_en_MM_fc    = 1'b1;
                enable_MM_out_fc = 1'b1;
                busy             = 1'b1;
                // The final row's product is folded in on this same edge.
                if (in_valid && (row_cnt == LAST_ROW)) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Row counter: cleared on start, advanced once per accepted activation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_cnt <= '0;
        end else if (clear_acc) begin
            row_cnt <= '0;
        end else if (handshake) begin
            row_cnt <= row_cnt + 1'b1;
        end
    end

    // Full-precision signed product of the activation with each weight lane.
    always_comb begin
        for (int k = 0; k < parallel_fc_PE; k++) begin
            prod[k] = PROD_WIDTH'($signed(in_data))
                    * PROD_WIDTH'($signed(dataMainMemo_fc[k*DATA_WIDTH +: DATA_WIDTH]));
        end
    end

    // Per-lane accumulators: cleared on start, summed on each handshake.
    // NOTE: the accumulators are plain flops, not a RAM, so they take the
    // async reset; out_data must read 0 during reset and reuses them directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < parallel_fc_PE; k++) begin
                acc[k] <= '0;
            end
        end else if (clear_acc) begin
            for (int k = 0; k < parallel_fc_PE; k++) begin
                acc[k] <= '0;
            end
        end else if (handshake) begin
            for (int k = 0; k < parallel_fc_PE; k++) begin
                acc[k] <= acc[k] + ACC_WIDTH'(prod[k]);
            end
        end
    end

    // Flatten the accumulators onto out_data; they persist after OUT.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < parallel_fc_PE; k++) begin
            out_data[k*ACC_WIDTH +: ACC_WIDTH] = acc[k];
        end
    end

    // One-cycle done pulse following the cycle the result was accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done <= 1'b0;
        end else begin
            done <= (state == OUT) && out_ready;
        end
    end

endmodule

// File: tb/tb_fc_mac_controller.sv
// Directed bench for fc_mac_controller with 2 lanes, 4 rows, 8-bit data.
// A table of passes (activations, weights, expected sums, stall options) is
// replayed through one pass task; reset-abort is a hand-written sequence.
module tb_fc_mac_controller;

    localparam int DW   = 8;
    localparam int AW   = 9;
    localparam int PE   = 2;
    localparam int ROWS = 4;
    localparam int ACCW = 2*DW+AW;

    logic               clk;
    logic               reset;
    logic               start;
    logic               in_valid;
    logic [DW-1:0]      in_data;
    logic               in_ready;
    logic [AW-1:0]      address_fc;
    logic               read_en_MM_fc;
    logic               enable_MM_out_fc;
    logic [DW*PE-1:0]   dataMainMemo_fc;
    logic               out_valid;
    logic               out_ready;
    logic [ACCW*PE-1:0] out_data;
    logic               busy;
    logic               done;

    logic [DW-1:0] wmem0 [ROWS];
    logic [DW-1:0] wmem1 [ROWS];

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0][7:0] din;
        logic [3:0][7:0] w0;
        logic [3:0][7:0] w1;
        int              exp0;
        int              exp1;
        int              gap;
        int              hold;
        logic            start_in_run;
    } vec_t;

    vec_t vecs [6];

    fc_mac_controller #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .parallel_fc_PE(PE),
        .fc_rows(ROWS), .ACC_WIDTH(ACCW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .address_fc(address_fc),
        .read_en_MM_fc(read_en_MM_fc), .enable_MM_out_fc(enable_MM_out_fc),
        .dataMainMemo_fc(dataMainMemo_fc), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done)
    );

    // Combinational weight memory: lane data follows the presented address.
    assign dataMainMemo_fc = {wmem1[address_fc[1:0]], wmem0[address_fc[1:0]]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic longint lane(input int k);
        logic signed [ACCW-1:0] v;
        v = out_data[k*ACCW +: ACCW];
        return longint'(v);
    endfunction

    function automatic logic [3:0][7:0] p4(input int a, input int b, input int c, input int d);
        logic [3:0][7:0] r;
        r[0] = a[7:0];
        r[1] = b[7:0];
        r[2] = c[7:0];
        r[3] = d[7:0];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pass(input vec_t v, input string tag);
        for (int r = 0; r < ROWS; r++) begin
            wmem0[r] = v.w0[r];
            wmem1[r] = v.w1[r];
        end
        // in_valid in IDLE must not start anything
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        check({tag, " idle_busy"}, busy, 0);
        check({tag, " idle_in_ready"}, in_ready, 0);
        check({tag, " idle_addr"}, address_fc, 0);
        in_valid = 1'b0;

        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " run_busy"}, busy, 1);
        check({tag, " run_rd_en"}, read_en_MM_fc, 1);
        check({tag, " run_out_en"}, enable_MM_out_fc, 1);
        check({tag, " run_out_valid"}, out_valid, 0);

        for (int r = 0; r < ROWS; r++) begin
            if (r == 2) begin
                for (int g = 0; g < v.gap; g++) begin
                    in_valid = 1'b0;
                    start    = v.start_in_run;
                    tick();
                    start = 1'b0;
                    check({tag, " gap_addr"}, address_fc, 2);
                    check({tag, " gap_busy"}, busy, 1);
                end
            end
            check({tag, $sformatf(" addr_row%0d", r)}, address_fc, r);
            check({tag, $sformatf(" ready_row%0d", r)}, in_ready, 1);
            in_valid = 1'b1;
            in_data  = v.din[r];
            tick();
        end
        in_valid = 1'b0;

        check({tag, " out_valid"}, out_valid, 1);
        check({tag, " out_in_ready"}, in_ready, 0);
        check({tag, " out_addr"}, address_fc, 0);
        check({tag, " out_rd_en"}, read_en_MM_fc, 0);
        check({tag, " lane0"}, lane(0), v.exp0);
        check({tag, " lane1"}, lane(1), v.exp1);

        for (int h = 0; h < v.hold; h++) begin
            in_valid = 1'b1;
            in_data  = 8'h7f;
            start    = 1'b1;
            tick();
            check({tag, " hold_valid"}, out_valid, 1);
            check({tag, " hold_lane0"}, lane(0), v.exp0);
            check({tag, " hold_lane1"}, lane(1), v.exp1);
            check({tag, " hold_done"}, done, 0);
        end
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " done_pulse"}, done, 1);
        check({tag, " idle_out_valid"}, out_valid, 0);
        check({tag, " idle_busy_after"}, busy, 0);
        check({tag, " kept_lane0"}, lane(0), v.exp0);
        tick();
        check({tag, " done_cleared"}, done, 0);
        check({tag, " kept_lane1"}, lane(1), v.exp1);
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            wmem0[r] = '0;
            wmem1[r] = '0;
        end

        // Basic pass: 1*(1+2+3+4)=10, 1*(-1)*4=-4
        vecs[0].din = p4(1, 1, 1, 1);
        vecs[0].w0  = p4(1, 2, 3, 4);
        vecs[0].w1  = p4(-1, -1, -1, -1);
        vecs[0].exp0 = 10;  vecs[0].exp1 = -4;
        vecs[0].gap = 0;    vecs[0].hold = 0;  vecs[0].start_in_run = 1'b0;
        // Same pass with a 3-cycle in_valid gap before row 2
        vecs[1] = vecs[0];
        vecs[1].gap = 3;
        // Start pulsed during the gap and during OUT; out_ready held off 5 cycles
        vecs[2] = vecs[0];
        vecs[2].gap = 2;    vecs[2].hold = 5;  vecs[2].start_in_run = 1'b1;
        // 1+4+9+16=30, -(1+2+3+4)=-10
        vecs[3] = vecs[0];
        vecs[3].din = p4(1, 2, 3, 4);
        vecs[3].exp0 = 30;  vecs[3].exp1 = -10;
        // (-128)*(-128)*4=65536, (-128)*127*4=-65024
        vecs[4].din = p4(-128, -128, -128, -128);
        vecs[4].w0  = p4(-128, -128, -128, -128);
        vecs[4].w1  = p4(127, 127, 127, 127);
        vecs[4].exp0 = 65536; vecs[4].exp1 = -65024;
        vecs[4].gap = 0;    vecs[4].hold = 1;  vecs[4].start_in_run = 1'b0;
        // 0-35-30+2=-63, 0+15+0+200=215
        vecs[5].din = p4(0, 5, -3, 2);
        vecs[5].w0  = p4(2, -7, 10, 1);
        vecs[5].w1  = p4(-4, 3, 0, 100);
        vecs[5].exp0 = -63; vecs[5].exp1 = 215;
        vecs[5].gap = 1;    vecs[5].hold = 2;  vecs[5].start_in_run = 1'b0;

        // Reset state
        #3;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_addr", address_fc, 0);
        check("rst_out_data", longint'(out_data), 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_pass(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset mid-RUN after two handshakes abandons the pass
        for (int r = 0; r < ROWS; r++) begin
            wmem0[r] = vecs[0].w0[r];
            wmem1[r] = vecs[0].w1[r];
        end
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'd1;
        tick();
        tick();
        check("abort_addr_before", address_fc, 2);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_rd_en", read_en_MM_fc, 0);
        check("abort_out_en", enable_MM_out_fc, 0);
        check("abort_addr", address_fc, 0);
        check("abort_out_data", longint'(out_data), 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("abort_no_done", done, 0);
        check("abort_stays_idle", busy, 0);
        run_pass(vecs[0], "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
